// File: rtl/voice_allocator_if.sv
// Purpose: key-switch input and per-voice oscillator/envelope outputs of the voice allocator.
// Latency: none (signal bundle only).
// Backpressure: none; outputs are level/pulse signals with no handshake.
interface voice_allocator_if #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 4,
    parameter int ACC_BITS   = 24
);
    logic [NUM_KEYS-1:0]            sw_in;
    logic [NUM_VOICES*ACC_BITS-1:0] voice_inc_out;
    logic [NUM_VOICES-1:0]          voice_gate_out;
    logic [NUM_VOICES-1:0]          voice_trig_out;
    logic                           busy_out;

    // Panel / stimulus side
    modport master (
        output sw_in,
        input  voice_inc_out,
        input  voice_gate_out,
        input  voice_trig_out,
        input  busy_out
    );

    // Allocator side
    modport slave (
        input  sw_in,
        output voice_inc_out,
        output voice_gate_out,
        output voice_trig_out,
        output busy_out
    );
endinterface

// File: rtl/voice_allocator.sv
// Purpose: debounce key switches, queue press/release events and map keys onto oscillator voices.
// Latency: 2 sync + DEBOUNCE_CYCLES to accept a key change, then 1 cycle per queued event.
// Backpressure: none; events queue in pending bitmaps, one serviced per cycle, busy_out flags backlog.
module voice_allocator #(
    parameter int NUM_KEYS        = 8,
    parameter int NUM_VOICES      = 4,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    voice_allocator_if.slave   bus
);
    localparam int SYNTH_PHASE_ACC_BITS = 24;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Tuning table; keys beyond the table play silence.
    function automatic logic [SYNTH_PHASE_ACC_BITS-1:0] tune(input logic [KW-1:0] key);
        logic [SYNTH_PHASE_ACC_BITS-1:0] r;
        case (int'(key))
            0:       r = 24'h00E107;
            1:       r = 24'h00D465;
            2:       r = 24'h00C87A;
            3:       r = 24'h00BD3A;
            4:       r = 24'h00B29A;
            5:       r = 24'h00A894;
            6:       r = 24'h009F1E;
            7:       r = 24'h009630;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Input path state
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] db_q, db_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];

    // Event queue
    logic [NUM_KEYS-1:0] press_pend_q, press_pend_d;
    logic [NUM_KEYS-1:0] release_pend_q, release_pend_d;

    // Voice state
    logic [KW-1:0]                   vkey_q [NUM_VOICES];
    logic [KW-1:0]                   vkey_d [NUM_VOICES];
    logic [7:0]                      age_q  [NUM_VOICES];
    logic [7:0]                      age_d  [NUM_VOICES];
    logic [SYNTH_PHASE_ACC_BITS-1:0] inc_q  [NUM_VOICES];
    logic [SYNTH_PHASE_ACC_BITS-1:0] inc_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]           active_q, active_d;
    logic [NUM_VOICES-1:0]           trig_q, trig_d;

    // Service selection
    logic [KW-1:0] rel_key, prs_key;
    logic          rel_any, prs_any;

    // Synchronise raw switches and debounce each key with its own run-length counter.
    always_comb begin
        sync1_d = bus.sw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    db_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Pick the lowest pending release and the lowest pending press.
    always_comb begin
        rel_key = '0;
        prs_key = '0;
        rel_any = |release_pend_q;
        prs_any = |press_pend_q;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (release_pend_q[k]) rel_key = KW'(k);
            if (press_pend_q[k])   prs_key = KW'(k);
        end
    end

    // Service one event per cycle (releases first), then merge newly debounced edges into the queue.
    always_comb begin
        logic            found;
        logic [KW-1:0]   pick;
        logic [7:0]      best_age;
        press_pend_d   = press_pend_q;
        release_pend_d = release_pend_q;
        active_d       = active_q;
        trig_d         = '0;
        found          = 1'b0;
        pick           = '0;
        best_age       = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            vkey_d[v] = vkey_q[v];
            age_d[v]  = age_q[v];
            inc_d[v]  = inc_q[v];
        end

        if (rel_any) begin
            release_pend_d[rel_key] = 1'b0;
            if (press_pend_q[rel_key]) begin
                // Press and release both queued: the key never sounded, drop both.
                press_pend_d[rel_key] = 1'b0;
            end else begin
                // Silence the voice still holding this key; a stolen key finds none.
                for (int v = NUM_VOICES - 1; v >= 0; v--) begin
                    if (active_q[v] && vkey_q[v] == rel_key) begin
                        found = 1'b1;
                        pick  = KW'(v);
                    end
                end
                if (found) active_d[pick] = 1'b0;
            end
        end else if (prs_any) begin
            press_pend_d[prs_key] = 1'b0;
            // Lowest free voice, else the oldest busy one (ties to lowest index).
            for (int v = NUM_VOICES - 1; v >= 0; v--) begin
                if (!active_q[v]) begin
                    found = 1'b1;
                    pick  = KW'(v);
                end
            end
            if (!found) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (v == 0 || age_q[v] > best_age) begin
                        best_age = age_q[v];
                        pick     = KW'(v);
                    end
                end
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (KW'(v) == pick) begin
                    vkey_d[v]   = prs_key;
                    age_d[v]    = '0;
                    inc_d[v]    = tune(prs_key);
                    active_d[v] = 1'b1;
                    trig_d[v]   = 1'b1;
                end else if (active_q[v] && age_q[v] != 8'hFF) begin
                    age_d[v] = age_q[v] + 8'd1;
                end
            end
        end

        press_pend_d   = press_pend_d   | (db_d & ~db_q);
        release_pend_d = release_pend_d | (~db_d & db_q);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            db_q           <= '0;
            press_pend_q   <= '0;
            release_pend_q <= '0;
            active_q       <= '0;
            trig_q         <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vkey_q[v] <= '0;
                age_q[v]  <= '0;
                inc_q[v]  <= '0;
            end
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_q           <= db_d;
            press_pend_q   <= press_pend_d;
            release_pend_q <= release_pend_d;
            active_q       <= active_d;
            trig_q         <= trig_d;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
            for (int v = 0; v < NUM_VOICES; v++) begin
                vkey_q[v] <= vkey_d[v];
                age_q[v]  <= age_d[v];
                inc_q[v]  <= inc_d[v];
            end
        end
    end

    // Pack per-voice increments onto the flat output bus.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.voice_inc_out[v*SYNTH_PHASE_ACC_BITS +: SYNTH_PHASE_ACC_BITS] = inc_q[v];
        end
    end

    assign bus.voice_gate_out = active_q;
    assign bus.voice_trig_out = trig_q;
    assign bus.busy_out       = |(press_pend_q | release_pend_q);

endmodule
